apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB requester (initiator) for the two-slave peripheral bus. It converts a simple single-outstanding command interface into APB SETUP/ACCESS transfers.
- Drives PSEL1/PSEL2, PENABLE, PWRITE, PADDR and PWDATA. Samples the shared PREADY and the muxed PRDATA1/PRDATA2.
- Returns read data or an error on a one-cycle response strobe.

Parameters:
- ADDR_W, 8, APB address width; bits [7:6] select the slave, bits [5:0] give the location.
- DATA_W, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  bus clock; all logic rising-edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads.
- rsp_err  out  1  error flag, valid with rsp_valid.
- PSEL1  out  1  select for slave 1 (cmd_addr[7:6] = 00).
- PSEL2  out  1  select for slave 2 (cmd_addr[7:6] = 01).
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA1  in  DATA_W  slave 1 read data.
- PRDATA2  in  DATA_W  slave 2 read data.
- PREADY  in  1  shared ready (ORed slave PREADY).

Behaviour:
- Reset (PRESETn low, asynchronous):
  - State returns to IDLE.
  - cmd_ready=0 during reset, then 1 in the first IDLE cycle after release.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - PSEL1=PSEL2=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
- States are IDLE, SETUP, ACCESS and DONE, all registered.
- IDLE:
  - cmd_ready=1 and all PSELs are low.
  - On accept, the command is latched into PADDR/PWDATA/PWRITE and the slave index is decoded.
  - A valid slave (00 or 01) goes to SETUP.
  - Addr[7:6] = 10 or 11 goes to DONE with err=1. No PSEL ever rises.
- SETUP:
  - Exactly one cycle, with the selected PSELx=1 and PENABLE=0. Next state is ACCESS.
- ACCESS:
  - PSELx=1 and PENABLE=1. PADDR, PWDATA and PWRITE stay stable for the whole transfer.
  - Stays in ACCESS while PREADY=0; there is no limit unless the optional feature is enabled.
  - On the edge where PREADY=1:
    - For reads, captures PRDATA1 or PRDATA2 according to the latched index.
    - Drops PSELx and PENABLE.
    - Goes to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_err hold their captured values. Next state is IDLE.
  - rsp_rdata is 0 for writes and for error responses.
  - cmd_ready=0 in SETUP, ACCESS and DONE.
- Latency:
  - Minimum with a registered-PREADY slave is accept edge → SETUP → ACCESS ×2 → DONE, i.e. rsp_valid 4 cycles after accept.
  - Command throughput is 1 per 5 cycles minimum; there is always one IDLE cycle between transfers.
- cmd_* inputs are ignored outside IDLE.
- There is no response backpressure; the consumer must take rsp_valid when it fires.
- PREADY is ignored outside ACCESS.
- Reset mid-transfer: outputs drop to reset values immediately and asynchronously. The aborted transfer produces no rsp_valid.

Optional Feature:
- Macro name: APB_TIMEOUT_EN.
- Defined:
  - A saturating counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY still 0, the master drops PSEL/PENABLE and goes to DONE with rsp_err=1 and rsp_rdata=0.
  - If PREADY=1 in that same cycle, the transfer completes normally with rsp_err=0.
- Undefined: no counter logic is built; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg:
  - State encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3).
  - Slave region constants (SLV1_REGION=2'b00, SLV2_REGION=2'b01).
  - ADDR_W and DATA_W defaults.
- Sub-module apb_addr_decode (combinational):
  - Input addr[7:6]; outputs are one-hot sel[1:0] and decode_err.
  - The slave testbench model reuses it.

Test Plan:
- Write to slave 2: cmd addr=8'h45, wdata=8'hA5, write.
  - Required: PSEL2=1 and PENABLE=0 for exactly 1 cycle, then PENABLE=1 until PREADY.
  - Required: PADDR=8'h45 and PWDATA=8'hA5 stable throughout; rsp_valid single pulse with rsp_err=0.
- Read-back: read addr=8'h45 after the write above.
  - Required: rsp_rdata=8'hA5, rsp_err=0, PSEL1 never asserted.
- Decode error: read addr=8'hC3.
  - Required: no PSEL or PENABLE activity; rsp_valid 1 cycle after accept with rsp_err=1 and rsp_rdata=0.
- Wait states: slave-1 model holds PREADY=0 for 5 ACCESS cycles, read addr=8'h10, PRDATA1=8'h3C.
  - Required: PENABLE held 6 cycles, rsp_rdata=8'h3C, cmd_ready=0 throughout.
- Reset mid-ACCESS: assert PRESETn=0 during a PREADY=0 ACCESS.
  - Required: PSEL/PENABLE go low the same cycle with no rsp_valid, and cmd_ready=1 in the first IDLE cycle after release.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16: PREADY tied 0.
  - Required: transfer aborts after 16 ACCESS cycles with rsp_err=1; the next command is accepted normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    localparam logic [1:0] SLV1_REGION = 2'b00;
    localparam logic [1:0] SLV2_REGION = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the two region bits of an APB address onto a one-hot slave select.
module apb_addr_decode
    import apb_pkg::*;
(
    input  logic [1:0] region_i,
    output logic [1:0] sel_o,
    output logic       decode_err_o
);

    always_comb begin
        sel_o        = 2'b00;
        decode_err_o = 1'b0;
        unique case (region_i)
            SLV1_REGION: sel_o = 2'b01;
            SLV2_REGION: sel_o = 2'b10;
            default:     decode_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command to APB SETUP/ACCESS requester for two slaves.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY
);

    apb_state_e        state_q, state_d;
    logic [1:0]        psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        dec_sel;
    logic              dec_err;
    logic              timeout;

    apb_addr_decode u_decode (
        .region_i     (cmd_addr[ADDR_W-1 -: 2]),
        .sel_o        (dec_sel),
        .decode_err_o (dec_err)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    // Saturates at TO_LAST; the counter is zero in the first ACCESS cycle.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY && to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (to_cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    rdata_d  = '0;
                    err_d    = dec_err;
                    if (dec_err) begin
                        state_d = DONE;
                    end else begin
                        psel_d  = dec_sel;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = 2'b00;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        rdata_d = psel_q[1] ? PRDATA2 : PRDATA1;
                    end
                    state_d = DONE;
                end else if (timeout) begin
                    psel_d    = 2'b00;
                    penable_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 2'b00;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Gated by reset so the requester never looks ready while held in reset.
    assign cmd_ready = (state_q == IDLE) && PRESETn;
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL1     = psel_q[0];
    assign PSEL2     = psel_q[1];
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a two-slave memory model.
// Timeout scenarios are exercised only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA1, PRDATA2;
    logic       PREADY = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
    );

    logic [1:0] dec_sel;
    logic       dec_err;

    apb_addr_decode u_slv_dec (
        .region_i(PADDR[7:6]), .sel_o(dec_sel), .decode_err_o(dec_err)
    );

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         lat;
        int         acc;
        logic [1:0] sel;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    bit   active = 0;
    int   k = 0;
    int   wait_target = 0;
    int   acc_cnt = 0;

    logic [7:0] smem1[64], smem2[64];
    logic [7:0] rmem1[64], rmem2[64];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Slave model: waits wait_target ACCESS cycles; PREADY is noise elsewhere.
    always @(negedge PCLK) begin
        if ((PSEL1 || PSEL2) && PENABLE) begin
            PREADY = (acc_cnt >= wait_target);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY = 1'($urandom);
        end
    end

    assign PRDATA1 = smem1[PADDR[5:0]];
    assign PRDATA2 = smem2[PADDR[5:0]];

    always @(posedge PCLK) begin
        if (PENABLE && PREADY && PWRITE && !dec_err) begin
            if (PSEL1 && dec_sel[0]) smem1[PADDR[5:0]] <= PWDATA;
            if (PSEL2 && dec_sel[1]) smem2[PADDR[5:0]] <= PWDATA;
        end
    end

    // Monitor / scoreboard
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            active = 0;
            exp_q.delete();
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
            check("rst_apb", {PSEL2, PSEL1, PENABLE, PWRITE}, 0);
            check("rst_addr_data", {PADDR, PWDATA}, 0);
        end else if (active) begin
            logic [1:0] esel;
            logic       een;
            k++;
            esel = (!cur.err && k <= cur.acc + 1) ? cur.sel : 2'b00;
            een  = !cur.err && k >= 2 && k <= cur.acc + 1;
            check("psel", {PSEL2, PSEL1}, esel);
            check("penable", PENABLE, een);
            if (esel != 2'b00) begin
                check("paddr", PADDR, cur.addr);
                check("pwrite", PWRITE, cur.wr);
                if (cur.wr) check("pwdata", PWDATA, cur.wdata);
            end
            check("busy_cmd_ready", cmd_ready, 0);
            check("rsp_valid", rsp_valid, k == cur.lat);
            if (k >= cur.lat) begin
                check("rsp_err", rsp_err, cur.err);
                check("rsp_rdata", rsp_rdata, cur.rdata);
                active = 0;
            end
        end else begin
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_apb", {PSEL2, PSEL1, PENABLE}, 0);
            check("idle_cmd_ready", cmd_ready, 1);
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: accept with no expected entry at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1;
                    k = 0;
                end
            end
        end
    end

    function automatic exp_t model(bit wr, logic [7:0] addr, logic [7:0] wd, int waits);
        exp_t e;
        bit   to;
        to = 0;
`ifdef APB_TIMEOUT_EN
        to = (waits >= TO);
`endif
        e.wr = wr;
        e.addr = addr;
        e.wdata = wd;
        e.rdata = 8'h00;
        if (addr[7:6] >= 2'd2) begin
            e.err = 1;
            e.acc = 0;
            e.lat = 1;
            e.sel = 2'b00;
        end else begin
            e.sel = (addr[7:6] == 2'd0) ? 2'b01 : 2'b10;
            if (to) begin
                e.err = 1;
                e.acc = TO;
                e.lat = TO + 2;
            end else begin
                e.err = 0;
                e.acc = waits + 1;
                e.lat = waits + 3;
                if (wr) begin
                    if (e.sel[0]) rmem1[addr[5:0]] = wd;
                    else rmem2[addr[5:0]] = wd;
                end else begin
                    e.rdata = e.sel[0] ? rmem1[addr[5:0]] : rmem2[addr[5:0]];
                end
            end
        end
        return e;
    endfunction

    task automatic start_cmd(bit wr, logic [7:0] addr, logic [7:0] wd, int waits,
                             output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge PCLK);
            #2;
            if (cmd_ready && !active) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_wait: never ready at %0t", $time);
            return;
        end
        wait_target = waits;
        exp_q.push_back(model(wr, addr, wd, waits));
        cmd_valid = 1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_wdata = wd;
        @(posedge PCLK);
        #2;
        cmd_valid = 0;
        cmd_write = 1'($urandom);
        cmd_addr = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic issue(bit wr, logic [7:0] addr, logic [7:0] wd, int waits);
        bit ok;
        bit fin;
        start_cmd(wr, addr, wd, waits, ok);
        if (!ok) return;
        fin = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!active && exp_q.size() == 0) begin
                fin = 1;
                break;
            end
            @(posedge PCLK);
            #2;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL rsp_wait: no completion at %0t", $time);
        end
        repeat ($urandom_range(0, 2)) @(posedge PCLK);
    endtask

    task automatic reset_mid_access();
        bit ok;
        start_cmd(0, 8'h07, 8'h00, 200, ok);
        if (!ok) return;
        repeat (3) @(posedge PCLK);
        #3;
        PRESETn = 0;
        #1;
        check("arst_psel", {PSEL2, PSEL1, PENABLE}, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge PCLK);
        #2;
        PRESETn = 1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            smem1[i] = 8'($urandom);
            smem2[i] = 8'($urandom);
            rmem1[i] = smem1[i];
            rmem2[i] = smem2[i];
        end
        repeat (3) @(posedge PCLK);
        #2;
        PRESETn = 1;

        issue(1, 8'h45, 8'hA5, 1);
        issue(0, 8'h45, 8'h00, 1);
        issue(0, 8'hC3, 8'h00, 1);
        issue(1, 8'h10, 8'h3C, 0);
        issue(0, 8'h10, 8'h00, 5);
        issue(1, 8'h82, 8'h11, 0);
`ifdef APB_TIMEOUT_EN
        issue(0, 8'h20, 8'h00, 1000);
        issue(1, 8'h21, 8'h5A, 1000);
        issue(0, 8'h21, 8'h00, 15);
        issue(1, 8'h22, 8'h77, 1);
`endif
        for (int n = 0; n < 120; n++) begin
            int w;
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 20))
                                            : int'($urandom_range(0, 3));
            issue(1'($urandom), 8'($urandom), 8'($urandom), w);
        end

        reset_mid_access();
        for (int n = 0; n < 6; n++) begin
            issue(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
